// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Mode codes, FSM state encoding and helpers for shift_unit_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic mode_is_valid(input logic [2:0] mode);
        return (mode <= MODE_ROR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_step_comb.sv
// ============================================================================
// Module      : shift_step_comb
// Description : Combinational single-step shifter/rotator by k bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step_comb
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] d,
    input  logic [KW-1:0]    k,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             carry
);

    localparam logic [KW-1:0] C_WIDTH = KW'(WIDTH);
    localparam logic [KW-1:0] C_ONE   = KW'(1);

    // Bit 0 of w_lo is d[k-1]; bit 0 of w_hi is d[WIDTH-k].
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;

    assign w_lo = d >> (k - C_ONE);
    assign w_hi = d >> (C_WIDTH - k);

    always_comb begin
        q     = d;
        carry = 1'b0;
        case (mode)
            MODE_SLL: begin
                q     = d << k;
                carry = w_hi[0];
            end
            MODE_SRL: begin
                q     = d >> k;
                carry = w_lo[0];
            end
            MODE_SRA: begin
                q     = $signed(d) >>> k;
                carry = w_lo[0];
            end
            MODE_ROL: begin
                q     = (d << k) | (d >> (C_WIDTH - k));
                carry = w_hi[0];
            end
            MODE_ROR: begin
                q     = (d >> k) | (d << (C_WIDTH - k));
                carry = w_lo[0];
            end
            default: begin
                q     = d;
                carry = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/shift_unit_seq.sv
// ============================================================================
// Module      : shift_unit_seq
// Description : Multi-cycle shifter/rotator, STEP bits per cycle, valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    output logic             busy
);

    // Remaining count is one bit wider than the amount so STEP == WIDTH fits.
    localparam int            KW     = $clog2(WIDTH + 1);
    localparam logic [KW-1:0] C_STEP = KW'(STEP);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [KW-1:0]    r_rem;
    logic [2:0]       r_mode;
    logic             r_carry;
    logic             r_err;

    logic [KW-1:0]    w_k;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_carry;

    assign w_k = (r_rem < C_STEP) ? r_rem : C_STEP;

    shift_step_comb #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .d     (r_data),
        .k     (w_k),
        .mode  (r_mode),
        .q     (w_step_q),
        .carry (w_step_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_mode  <= MODE_SLL;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_rem   <= KW'(in_amt);
                        r_mode  <= in_mode;
                        r_carry <= 1'b0;
                        r_err   <= !mode_is_valid(in_mode);
                        if ((in_amt != '0) && mode_is_valid(in_mode)) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_data  <= w_step_q;
                    r_carry <= w_step_carry;
                    r_rem   <= r_rem - w_k;
                    if (r_rem <= C_STEP) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_data;
    assign out_carry = r_carry;
    assign out_zero  = (r_data == '0);
    assign out_err   = r_err;

endmodule

`default_nettype wire
